dram_cycle_monitor: RTL and testbench

Classifies each Amiga DRAM bus cycle from RAS_n, CASU_n, CASL_n and WE_n before the cycle reaches the SRAM address/strobe translator. It samples the asynchronous strobes in one system clock domain and reports each cycle as read, write, RAS-only refresh or CAS-before-RAS (CBR) refresh. It drives `refresh_gate_n` so the SRAM enable logic downstream can suppress chip enable during CBR refresh. It also counts refreshes and flags protocol violations for debug.

---
 rtl/dram_cycle_monitor_if.sv | 30 +++
 rtl/dram_cycle_monitor.sv | 160 ++++++++++++++++
 tb/tb_dram_cycle_monitor.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/dram_cycle_monitor_if.sv
// Amiga DRAM strobe bus and classification results for dram_cycle_monitor.
// master drives the raw strobes and err_clr; slave is the monitor.
interface dram_cycle_monitor_if #(
  parameter int REFRESH_CNT_W = 16
);
  logic                     RAS_n;
  logic                     CASU_n;
  logic                     CASL_n;
  logic                     WE_n;
  logic                     err_clr;
  logic                     cycle_strobe;
  logic [1:0]               cycle_type;
  logic [1:0]               byte_lanes;
  logic                     refresh_gate_n;
  logic [REFRESH_CNT_W-1:0] refresh_count;
  logic                     protocol_err;
  logic                     refresh_timeout;

  modport master (
    output RAS_n, CASU_n, CASL_n, WE_n, err_clr,
    input  cycle_strobe, cycle_type, byte_lanes, refresh_gate_n,
           refresh_count, protocol_err, refresh_timeout
  );

  modport slave (
    input  RAS_n, CASU_n, CASL_n, WE_n, err_clr,
    output cycle_strobe, cycle_type, byte_lanes, refresh_gate_n,
           refresh_count, protocol_err, refresh_timeout
  );
endinterface

// File: rtl/dram_cycle_monitor.sv
// Classifies Amiga DRAM cycles (read/write/RAS-only/CBR) from synchronized strobes.
// Define REFRESH_WATCHDOG_EN to build the refresh watchdog behind refresh_timeout.
module dram_cycle_monitor #(
  parameter int SYNC_STAGES     = 2,
  parameter int CBR_WINDOW      = 8,
  parameter int REFRESH_CNT_W   = 16,
  parameter int REFRESH_TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 reset_n,
  dram_cycle_monitor_if.slave  bus
);
  localparam int WIN_W = $clog2(CBR_WINDOW + 1);

  typedef enum logic [2:0] {DRAIN, IDLE, ROW, ACCESS, CBR_PEND, CBR_ACT} state_t;

  logic [SYNC_STAGES-1:0][3:0] r_sync;
  logic [SYNC_STAGES-1:0]      r_prime;
  logic [3:0]                  w_raw, w_s;
  logic                        w_ras_s, w_we_s, w_cas, w_all_hi, w_last;
  logic [1:0]                  w_cas_lo;
  logic                        w_ref_ev, w_err_ev;

  state_t                      r_state;
  logic [WIN_W-1:0]            r_win;
  logic                        r_strobe, r_gate_n, r_perr;
  logic [1:0]                  r_type, r_lanes;
  logic [REFRESH_CNT_W-1:0]    r_count;

  assign w_raw    = {bus.RAS_n, bus.CASU_n, bus.CASL_n, bus.WE_n};
  assign w_s      = r_sync[SYNC_STAGES-1];
  assign w_ras_s  = w_s[3];
  assign w_cas_lo = {~w_s[2], ~w_s[1]};
  assign w_cas    = |w_cas_lo;
  assign w_we_s   = w_s[0];
  assign w_all_hi = w_ras_s & ~w_cas;
  assign w_last   = (r_win == WIN_W'(CBR_WINDOW - 1));

  // r_prime marks when the last sync stage holds sampled data rather than its
  // reset value, so a cycle in flight at reset release is never seen as idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync  <= '1;
      r_prime <= '0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], w_raw};
      r_prime <= {r_prime[SYNC_STAGES-2:0], 1'b1};
    end
  end

  always_comb begin
    w_ref_ev = 1'b0;
    w_err_ev = 1'b0;
    case (r_state)
      ROW:      w_ref_ev = ~w_cas & w_ras_s;
      CBR_PEND: begin
        w_ref_ev = ~w_ras_s;
        w_err_ev = w_ras_s & (~w_cas | w_last);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= DRAIN;
      r_win    <= '0;
      r_strobe <= 1'b0;
      r_type   <= 2'b00;
      r_lanes  <= 2'b00;
      r_gate_n <= 1'b1;
    end else begin
      r_strobe <= 1'b0;
      case (r_state)
        DRAIN: if (r_prime[SYNC_STAGES-1] && w_all_hi) r_state <= IDLE;
        IDLE: begin
          if (!w_ras_s) r_state <= ROW;
          else if (w_cas) begin
            r_state <= CBR_PEND;
            r_win   <= '0;
          end
        end
        ROW: begin
          if (w_cas) begin
            r_strobe <= 1'b1;
            r_type   <= {1'b0, ~w_we_s};
            r_lanes  <= w_cas_lo;
            r_state  <= ACCESS;
          end else if (w_ras_s) begin
            r_strobe <= 1'b1;
            r_type   <= 2'b10;
            r_lanes  <= 2'b00;
            r_state  <= IDLE;
          end
        end
        ACCESS: if (w_all_hi) r_state <= IDLE;
        CBR_PEND: begin
          if (!w_ras_s) begin
            r_strobe <= 1'b1;
            r_type   <= 2'b11;
            r_lanes  <= 2'b00;
            r_gate_n <= 1'b0;
            r_state  <= CBR_ACT;
          end else if (!w_cas) r_state <= IDLE;
          else if (w_last)     r_state <= DRAIN;
          else                 r_win   <= r_win + 1'b1;
        end
        CBR_ACT: begin
          if (w_all_hi) begin
            r_gate_n <= 1'b1;
            r_state  <= IDLE;
          end
        end
        default: r_state <= DRAIN;
      endcase
    end
  end

  // A set event beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_perr  <= 1'b0;
    end else begin
      if (w_ref_ev && r_count != '1) r_count <= r_count + 1'b1;
      if (w_err_ev)         r_perr <= 1'b1;
      else if (bus.err_clr) r_perr <= 1'b0;
    end
  end

`ifdef REFRESH_WATCHDOG_EN
  localparam int WD_W = $clog2(REFRESH_TIMEOUT + 1);
  logic [WD_W-1:0] r_wd;
  logic            r_tmo;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wd  <= '0;
      r_tmo <= 1'b0;
    end else begin
      if (w_ref_ev) r_wd <= '0;
      else if (r_wd != WD_W'(REFRESH_TIMEOUT)) r_wd <= r_wd + 1'b1;
      if (!w_ref_ev && r_wd >= WD_W'(REFRESH_TIMEOUT - 1)) r_tmo <= 1'b1;
      else if (bus.err_clr)                                  r_tmo <= 1'b0;
    end
  end

  assign bus.refresh_timeout = r_tmo;
`else
  localparam int unused_timeout = REFRESH_TIMEOUT;
  assign bus.refresh_timeout = 1'b0;
`endif

  assign bus.cycle_strobe   = r_strobe;
  assign bus.cycle_type     = r_type;
  assign bus.byte_lanes     = r_lanes;
  assign bus.refresh_gate_n = r_gate_n;
  assign bus.refresh_count  = r_count;
  assign bus.protocol_err   = r_perr;
endmodule

// File: tb/tb_dram_cycle_monitor.sv
// Self-checking bench for dram_cycle_monitor: a transaction schedule is built up front,
// expected outputs per clock are derived from each transaction's edge times.
module tb_dram_cycle_monitor;
  localparam int SYNC = 2;
  localparam int WIN  = 8;
  localparam int CW   = 4;
  localparam int TMO  = 100;
  localparam int D    = SYNC + 1;
  localparam int NS   = 8192;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;

  dram_cycle_monitor_if #(.REFRESH_CNT_W(CW)) bus ();

  dram_cycle_monitor #(
    .SYNC_STAGES(SYNC), .CBR_WINDOW(WIN), .REFRESH_CNT_W(CW), .REFRESH_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-slot raw stimulus (slot s = interval after clock edge s).
  bit       sr[NS], scu[NS], scl[NS], swe[NS], sclr[NS], srst[NS];
  // Per-edge expectations.
  bit       e_stb[NS], e_gl[NS], e_err[NS];
  bit [1:0] e_ty[NS], e_ln[NS];
  int       r_end, end_slot;
  int       n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp, input int e);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s edge=%0d actual=%0h required=%0h", nm, e, act, exp);
  endtask

  task automatic t_rw(input int t0, input int a, input bit [1:0] ln, input bit we,
                      input int hold, input bit tog, output int rel);
    rel = t0 + a + hold;
    for (int i = t0; i < rel; i++) begin sr[i] = 0; swe[i] = we; end
    for (int i = t0 + a; i < rel; i++) begin scu[i] = ~ln[1]; scl[i] = ~ln[0]; end
    if (tog && hold >= 3) begin scu[t0+a+1] = 1; scl[t0+a+1] = 1; end
    e_stb[t0+a+D] = 1; e_ty[t0+a+D] = {1'b0, ~we}; e_ln[t0+a+D] = ln;
  endtask

  task automatic t_ras(input int t0, input int h, output int rel);
    rel = t0 + h;
    for (int i = t0; i < rel; i++) sr[i] = 0;
    e_stb[rel+D] = 1; e_ty[rel+D] = 2'b10; e_ln[rel+D] = 2'b00;
  endtask

  task automatic t_cbr(input int t0, input bit [1:0] ln, input int k, input int h,
                       output int rel);
    rel = t0 + k + h;
    for (int i = t0; i < rel; i++) begin scu[i] = ~ln[1]; scl[i] = ~ln[0]; end
    for (int i = t0 + k; i < rel; i++) sr[i] = 0;
    e_stb[t0+k+D] = 1; e_ty[t0+k+D] = 2'b11; e_ln[t0+k+D] = 2'b00;
    for (int i = t0 + k + D; i < rel + D; i++) e_gl[i] = 1;
  endtask

  task automatic t_orphan(input int t0, input bit [1:0] ln, input int h, output int rel);
    rel = t0 + h;
    for (int i = t0; i < rel; i++) begin scu[i] = ~ln[1]; scl[i] = ~ln[0]; end
    e_err[t0 + ((h < WIN) ? h : WIN) + D] = 1;
  endtask

  task automatic gen();
    int s, rel, kind;
    for (int i = 0; i < NS; i++) begin
      sr[i] = 1; scu[i] = 1; scl[i] = 1; swe[i] = 1; sclr[i] = 0; srst[i] = 1;
    end
    srst[0] = 0; srst[1] = 0;
    t_rw(5, 3, 2'b01, 1'b1, 6, 1'b0, rel);
    t_rw(20, 2, 2'b11, 1'b0, 4, 1'b0, rel);
    t_ras(32, 6, rel);
    t_cbr(45, 2'b01, 3, 7, rel);
    t_orphan(62, 2'b01, 20, rel);
    sclr[90] = 1;
    s = 95;
    while (s < 6500) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1, 2: t_rw(s, $urandom_range(1, 4), 2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)),
                      $urandom_range(1, 8), 1'($urandom_range(0, 1)), rel);
        3, 4:    t_ras(s, $urandom_range(1, 8), rel);
        5, 6, 7: t_cbr(s, 2'($urandom_range(1, 3)), $urandom_range(1, WIN), $urandom_range(1, 6), rel);
        default: t_orphan(s, 2'($urandom_range(1, 3)), $urandom_range(1, 14), rel);
      endcase
      s = rel + (($urandom_range(0, 11) == 0) ? $urandom_range(110, 140) : $urandom_range(2, 6));
    end
    for (int i = 95; i < s; i++) if ($urandom_range(0, 19) == 0) sclr[i] = 1;
    // Reset lands in the middle of a read that stays active after release.
    r_end = s;
    for (int i = r_end; i < r_end + 12; i++) sr[i] = 0;
    for (int i = r_end + 1; i < r_end + 12; i++) scl[i] = 0;
    for (int i = r_end + 2; i < r_end + 5; i++) srst[i] = 0;
    t_rw(r_end + 20, 2, 2'b01, 1'b1, 6, 1'b0, rel);
    end_slot = r_end + 40;
  endtask

  task automatic apply(input int s);
    reset_n     = srst[s];
    bus.RAS_n   = sr[s];
    bus.CASU_n  = scu[s];
    bus.CASL_n  = scl[s];
    bus.WE_n    = swe[s];
    bus.err_clr = sclr[s];
  endtask

  // Compare process: running model of the sticky flags and counter.
  initial begin
    int  m_cnt, last_ref, e;
    bit  m_err, m_to, refr, wset;
    bit [1:0] m_ty, m_ln;
    m_cnt = 0; m_err = 0; m_to = 0; m_ty = 0; m_ln = 0; last_ref = 0;
    forever begin
      @(negedge clk);
      e = cyc;
      if (e < 1 || e > end_slot) continue;
      if (!srst[e-1] || !srst[e]) begin
        m_cnt = 0; m_err = 0; m_to = 0; m_ty = 0; m_ln = 0; last_ref = e;
        chk("reset_state",
            {bus.cycle_strobe, bus.cycle_type, bus.byte_lanes, bus.refresh_gate_n,
             bus.protocol_err, bus.refresh_timeout, 4'(bus.refresh_count)},
            {1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 4'h0}, e);
        continue;
      end
      refr = e_stb[e] && e_ty[e][1];
      if (e_stb[e]) begin
        m_ty = e_ty[e]; m_ln = e_ln[e];
        if (refr && m_cnt != CMAX) m_cnt++;
      end
      if (e_err[e]) m_err = 1;
      else if (sclr[e-1]) m_err = 0;
`ifdef REFRESH_WATCHDOG_EN
      if (refr) last_ref = e;
      wset = !refr && (e - last_ref >= TMO);
      if (wset) m_to = 1;
      else if (sclr[e-1]) m_to = 0;
`else
      wset = 0;
      m_to = 0;
`endif
      chk("strobe", bus.cycle_strobe, e_stb[e], e);
      chk("type", bus.cycle_type, m_ty, e);
      chk("lanes", bus.byte_lanes, m_ln, e);
      chk("gate_n", bus.refresh_gate_n, !e_gl[e], e);
      chk("count", bus.refresh_count, m_cnt, e);
      chk("perr", bus.protocol_err, m_err, e);
      chk("timeout", bus.refresh_timeout, m_to, e);
      // Hand-computed pins for the directed opening and the reset scenario.
      case (e)
        11: chk("lit_read", {bus.cycle_strobe, bus.cycle_type, bus.byte_lanes}, 5'b1_00_01, e);
        25: chk("lit_write", {bus.cycle_strobe, bus.cycle_type, bus.byte_lanes}, 5'b1_01_11, e);
        41: chk("lit_rasonly", {bus.cycle_strobe, bus.cycle_type, bus.byte_lanes, 4'(bus.refresh_count)},
                9'b1_10_00_0001, e);
        51: chk("lit_cbr", {bus.cycle_strobe, bus.cycle_type, bus.byte_lanes, bus.refresh_gate_n},
                6'b1_11_00_0, e);
        57: chk("lit_gate_low", bus.refresh_gate_n, 0, e);
        58: chk("lit_gate_high", bus.refresh_gate_n, 1, e);
        72: chk("lit_perr_pre", bus.protocol_err, 0, e);
        73: chk("lit_perr_set", {bus.protocol_err, bus.cycle_strobe}, 2'b10, e);
        91: chk("lit_perr_clr", bus.protocol_err, 0, e);
        default: ;
      endcase
      if (e == r_end + 10) chk("lit_rst_quiet", {bus.cycle_strobe, 4'(bus.refresh_count)}, 0, e);
      if (e == r_end + 25)
        chk("lit_rst_fresh", {bus.cycle_strobe, bus.cycle_type, bus.byte_lanes, 4'(bus.refresh_count)},
            9'b1_00_01_0000, e);
    end
  end

  initial begin
    gen();
    apply(0);
    while (cyc < end_slot) begin
      @(posedge clk);
      #1;
      apply(cyc);
    end
    @(negedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
